// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// It holds the PC and issues instruction-memory requests. Fetched words go to
// decode with their PC. Branch/jump redirects from ID flush the wrong-path slot.
// A one-entry buffer keeps a word that arrives while decode is stalled.
//
// state | meaning
// FETCH | request at pc; deliver, redirect or wait on the memory
// DRAIN | redirect taken mid-fetch; wait out the old request, then jump
// HOLD  | fetched word parked in buf while ID is stalled; no request
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Branch,
  input  logic [31:0] branch_target,
  input  logic        Jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  // Redirect is only honoured for a real, unstalled instruction in ID
  always_comb begin
    redirect = (Branch | Jump) & if_id_valid_q & ~stall;
    target   = Branch ? {branch_target[31:2], 2'b00} : {jump_target[31:2], 2'b00};
    pc_inc   = pc_q + 32'd4;
  end

  // Next-state, PC, hold-buffer and IF/ID register update
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_pc_d    = redir_pc_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_INSTR;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            // Address must stay put until the outstanding fetch completes
            redir_pc_d = target;
            state_d    = DRAIN;
          end
        end else if (!stall) begin
          if (imem_ready) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            pc_d          = pc_inc;
          end else begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
          end
        end else if (imem_ready) begin
          buf_pc_d    = pc_q;
          buf_instr_d = imem_rdata;
          pc_d        = pc_inc;
          state_d     = HOLD;
        end
      end
      DRAIN: begin
        if_id_valid_d = 1'b0;
        if_id_instr_d = NOP_INSTR;
        if (imem_ready) begin
          pc_d    = redir_pc_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_d = FETCH;
          if (redirect) begin
            pc_d          = target;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
          end else begin
            if_id_pc_d    = buf_pc_q;
            if_id_instr_d = buf_instr_q;
            if_id_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      redir_pc_q    <= 32'h0;
      buf_pc_q      <= 32'h0;
      buf_instr_q   <= 32'h0;
      if_id_pc_q    <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_pc_q    <= redir_pc_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_req    = ~rst & (state_q != HOLD);
  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. Memory returns addr + 0x1000.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        Branch;
  logic [31:0] branch_target;
  logic        Jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .Branch        (Branch),
    .branch_target (branch_target),
    .Jump          (Jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid)
  );

  assign imem_rdata = imem_addr + 32'h0000_1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic valid);
    chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, valid});
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".pc"}, if_id_pc, pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; Branch = 1'b0; branch_target = 32'h0; Jump = 1'b0; jump_target = 32'h0;
    stall = 1'b0; imem_ready = 1'b1;
    step(); step();
    chk_id("reset", 32'h0, 32'h13, 1'b0);
    chk("reset.req", {31'h0, imem_req}, 32'h0);
    chk("reset.addr", imem_addr, 32'h0);

    // Streaming with zero-wait memory
    rst = 1'b0; #1;
    chk("first.req", {31'h0, imem_req}, 32'h1);
    chk("first.addr", imem_addr, 32'h0);
    step(); chk_id("s0", 32'h0, 32'h1000, 1'b1);
    chk("s0.addr", imem_addr, 32'h4);
    step(); chk_id("s1", 32'h4, 32'h1004, 1'b1);
    step(); chk_id("s2", 32'h8, 32'h1008, 1'b1);
    chk("s2.addr", imem_addr, 32'hC);

    // Taken branch while ID holds pc 8
    Branch = 1'b1; branch_target = 32'h200;
    step(); Branch = 1'b0;
    chk_id("br.flush", 32'h8, 32'h13, 1'b0);
    chk("br.addr", imem_addr, 32'h200);
    step(); chk_id("br.tgt", 32'h200, 32'h1200, 1'b1);

    // Jump to 0xC so 0x10 is outstanding with a valid ID
    Jump = 1'b1; jump_target = 32'hC;
    step(); Jump = 1'b0;
    chk("j0c.addr", imem_addr, 32'hC);
    step(); chk_id("j0c.id", 32'hC, 32'h100C, 1'b1);
    chk("j0c.next", imem_addr, 32'h10);

    // Redirect while memory is waiting on 0x10
    imem_ready = 1'b0; Jump = 1'b1; jump_target = 32'h400;
    step(); Jump = 1'b0;
    chk_id("drain0", 32'hC, 32'h13, 1'b0);
    chk("drain0.addr", imem_addr, 32'h10);
    chk("drain0.req", {31'h0, imem_req}, 32'h1);
    step(); chk("drain1.addr", imem_addr, 32'h10);
    chk_id("drain1", 32'hC, 32'h13, 1'b0);
    step(); chk("drain2.addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    step(); chk_id("drain3", 32'hC, 32'h13, 1'b0);
    chk("drain3.addr", imem_addr, 32'h400);

    // Branch while ID is a bubble must be ignored
    Branch = 1'b1; branch_target = 32'h300;
    step(); Branch = 1'b0;
    chk_id("j400.id", 32'h400, 32'h1400, 1'b1);
    chk("gate.invalid.addr", imem_addr, 32'h404);

    // Set up a valid ID at 0x10 with 0x14 being fetched
    Jump = 1'b1; jump_target = 32'h10;
    step(); Jump = 1'b0;
    step(); chk_id("j10.id", 32'h10, 32'h1010, 1'b1);
    chk("j10.next", imem_addr, 32'h14);

    // Stall while the 0x14 fetch completes; Branch under stall is ignored
    stall = 1'b1;
    step(); chk_id("hold0", 32'h10, 32'h1010, 1'b1);
    chk("hold0.req", {31'h0, imem_req}, 32'h0);
    Branch = 1'b1; branch_target = 32'h500;
    step(); chk_id("hold1", 32'h10, 32'h1010, 1'b1);
    step(); chk_id("hold2", 32'h10, 32'h1010, 1'b1);
    chk("hold2.req", {31'h0, imem_req}, 32'h0);
    chk("hold2.addr", imem_addr, 32'h18);
    Branch = 1'b0; stall = 1'b0;
    step(); chk_id("release", 32'h14, 32'h1014, 1'b1);
    chk("release.addr", imem_addr, 32'h18);
    chk("release.req", {31'h0, imem_req}, 32'h1);
    step(); chk_id("after.rel", 32'h18, 32'h1018, 1'b1);

    // Stall, then release together with a taken branch
    stall = 1'b1;
    step(); chk("hold.b.req", {31'h0, imem_req}, 32'h0);
    stall = 1'b0; Branch = 1'b1; branch_target = 32'h80;
    step(); Branch = 1'b0;
    chk_id("relbr", 32'h18, 32'h13, 1'b0);
    chk("relbr.addr", imem_addr, 32'h80);
    step(); chk_id("relbr.tgt", 32'h80, 32'h1080, 1'b1);

    // Wrap-around; low target bits forced to zero
    Jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    step(); Jump = 1'b0;
    chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    step(); chk_id("wrap.id", 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b1);
    chk("wrap.next", imem_addr, 32'h0);
    step(); chk_id("wrap.zero", 32'h0, 32'h1000, 1'b1);

    // Reset aborts a pending HOLD
    stall = 1'b1;
    step(); chk("rsthold.req", {31'h0, imem_req}, 32'h0);
    rst = 1'b1; stall = 1'b0;
    step(); chk_id("rsthold", 32'h0, 32'h13, 1'b0);
    chk("rsthold.addr", imem_addr, 32'h0);
    chk("rsthold.req2", {31'h0, imem_req}, 32'h0);
    rst = 1'b0;
    step(); chk_id("rsthold.first", 32'h0, 32'h1000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage plus IF/ID pipeline register. It feeds the ID stage: it holds the PC, drives the instruction-memory request, and captures `{pc, instr}` for decode. It consumes the ID-stage `Branch` decision from the branch tester and the jump redirect, then flushes the wrong-path slot. It also absorbs hazard-unit stalls and variable instruction-memory latency through a one-entry hold buffer.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction word presented to ID on a bubble or flush (addi x0,x0,0).
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `Branch`, input, 1: taken-branch decision for the instruction currently in ID.
- `branch_target`, input, 32: branch target address.
- `Jump`, input, 1: jump redirect for the instruction in ID.
- `jump_target`, input, 32: jump target address.
- `stall`, input, 1: hazard-unit hold of the IF/ID register.
- `imem_req`, output, 1: fetch request.
- `imem_addr`, output, 32: fetch address. It is word-aligned and equal to the PC register.
- `imem_rdata`, input, 32: fetched word. It is valid in the cycle where `imem_ready` is 1.
- `imem_ready`, input, 1: fetch completes this cycle.
- `if_id_pc`, output, 32: PC of the instruction in ID.
- `if_id_instr`, output, 32: instruction in ID.
- `if_id_valid`, output, 1: the ID slot holds a real instruction.

## Operation
- **Redirect.**
  - `redirect = (Branch | Jump) & if_id_valid & ~stall`.
  - Target is `branch_target` if `Branch`, otherwise `jump_target`. `Branch` has priority if both are high.
  - `Branch`/`Jump` are ignored while `if_id_valid=0` or `stall=1`.
- **Normal fetch.**
  - PC increments by 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
  - Low two bits of the targets are forced to 0.
- **Address-stability rule.** While `imem_req=1` and `imem_ready=0`, `imem_addr` must not change.
- **FETCH state.** `imem_req=1`. Actions for each input combination:
  - redirect & `imem_ready`: discard `imem_rdata`; pc <= target; IF/ID <= bubble. Stay in FETCH.
  - redirect & ~`imem_ready`: redir_pc <= target; IF/ID <= bubble. Go to DRAIN.
  - ~redirect & ~stall & `imem_ready`: IF/ID <= {pc, `imem_rdata`, 1}; pc <= pc+4.
  - ~redirect & ~stall & ~`imem_ready`: IF/ID <= bubble.
  - stall & `imem_ready`: buf <= {pc, `imem_rdata`}; pc <= pc+4; IF/ID held. Go to HOLD.
  - stall & ~`imem_ready`: IF/ID held; keep waiting.
- **DRAIN state.** `imem_req=1` with the old address.
  - IF/ID <= bubble every cycle.
  - On `imem_ready`: discard data; pc <= redir_pc. Go to FETCH.
  - Redirects cannot occur here, because ID is invalid.
- **HOLD state.** `imem_req=0`.
  - While stall=1: IF/ID held.
  - When stall=0 and a redirect is present: discard buf; pc <= target; IF/ID <= bubble. Go to FETCH.
  - When stall=0 and no redirect: IF/ID <= {buf, 1}. Go to FETCH.
- **Bubble.** `if_id_valid=0`, `if_id_instr=NOP_INSTR`, `if_id_pc` unchanged.
- **Reset.** Overrides everything, including a pending DRAIN or HOLD.
  - state=FETCH, pc=`RESET_PC`, buf cleared.
  - `imem_req=0` during rst.
  - `if_id_valid=0`, `if_id_instr=NOP_INSTR`, `if_id_pc=RESET_PC`.

## Timing
- `imem_req = ~rst & (state != HOLD)`.
- `imem_addr` = pc register, a direct register output.
- IF/ID outputs are registered. Fetch completing at edge t appears in ID during cycle t+1.
- **Zero-wait memory.** Throughput is one instruction per cycle.
- **Taken-redirect penalty.**
  - `Branch` sampled at edge t (with `imem_ready=1`).
  - `imem_addr`=target during cycle t+1.
  - Target instruction valid in ID at t+2.
  - Exactly one flushed slot.
- **Redirect with a slow memory.** The target is requested in the cycle after the outstanding fetch's `imem_ready`.
- **First fetch after reset.** `imem_req` rises in the first cycle with rst=0, and `imem_addr=RESET_PC`.

## Test plan
- **Reset and streaming.**
  - Stimulus: `imem_ready`=1 always; memory returns addr+0x1000.
  - Required: after rst drops, ID shows pc 0,4,8 with instr 0x1000,0x1004,0x1008 on consecutive cycles. During rst, outputs are {valid 0, NOP 0x13, pc 0}.
- **Taken branch.**
  - Stimulus: `Branch`=1 with `branch_target`=0x200 while ID holds pc 0x8.
  - Required: next ID slot is a bubble (valid 0, 0x13). The following slot is pc 0x200. `imem_addr`=0x200 one cycle after `Branch`.
- **Redirect during wait.**
  - Stimulus: `imem_ready` held low 3 cycles on addr 0x10 while `Jump`=1 to 0x400.
  - Required: `imem_addr` stays 0x10 until ready; ID bubbles throughout; then `imem_addr`=0x400; word from 0x10 never valid in ID.
- **Stall with arriving data.**
  - Stimulus: stall=1 for 3 cycles while a fetch of 0x14 completes.
  - Required: IF/ID frozen; `imem_req`=0 in HOLD; on stall release, ID shows pc 0x14; next fetch address 0x18.
- **Stall release with branch in the same cycle.**
  - Stimulus: stall falls while `Branch`=1 with `branch_target`=0x80.
  - Required: buffered word dropped; ID bubble; next valid ID pc 0x80.
- **Wrap-around and gating.**
  - Wrap stimulus: pc 0xFFFF_FFFC fetched. Required: next `imem_addr` is 0.
  - Gating stimulus: `Branch`=1 while `if_id_valid`=0, or while stall=1. Required: no redirect.
